// File: rtl/ahb_lite_interconnect_if.sv
// AHB-Lite interconnect bus bundle: master-side signals (m_*) and the
// flattened slave-side signals (s_*) in one interface.
// The interconnect itself uses the "slave" modport (it is the slave seen by
// the core); the "master" modport is the surrounding core/slaves view.
interface ahb_lite_interconnect_if #(
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    // Master side
    logic [ADDR_WIDTH-1:0]            m_haddr;
    logic [1:0]                       m_htrans;
    logic                             m_hwrite;
    logic [2:0]                       m_hsize;
    logic [2:0]                       m_hburst;
    logic [3:0]                       m_hprot;
    logic                             m_hmastlock;
    logic [DATA_WIDTH-1:0]            m_hwdata;
    logic [DATA_WIDTH-1:0]            m_hrdata;
    logic                             m_hready;
    logic                             m_hresp;

    // Slave side
    logic [NUM_SLAVES-1:0]            s_hsel;
    logic [ADDR_WIDTH-1:0]            s_haddr;
    logic [1:0]                       s_htrans;
    logic                             s_hwrite;
    logic [2:0]                       s_hsize;
    logic [2:0]                       s_hburst;
    logic [3:0]                       s_hprot;
    logic                             s_hmastlock;
    logic [DATA_WIDTH-1:0]            s_hwdata;
    logic                             s_hready;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata;
    logic [NUM_SLAVES-1:0]            s_hreadyout;
    logic [NUM_SLAVES-1:0]            s_hresp;

    modport slave (
        input  m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hprot,
               m_hmastlock, m_hwdata,
        output m_hrdata, m_hready, m_hresp,
        output s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst,
               s_hprot, s_hmastlock, s_hwdata, s_hready,
        input  s_hrdata, s_hreadyout, s_hresp
    );

    modport master (
        output m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hprot,
               m_hmastlock, m_hwdata,
        input  m_hrdata, m_hready, m_hresp,
        input  s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst,
               s_hprot, s_hmastlock, s_hwdata, s_hready,
        output s_hrdata, s_hreadyout, s_hresp
    );
endinterface

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite interconnect: address decode to one-hot slave
// selects, registered data-phase select, response/read-data mux and a
// built-in default slave that answers unmapped transfers with ERROR.
module ahb_lite_interconnect #(
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE_ADDR =
        {32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_LAST_ADDR =
        {32'h0001_00FF, 32'h0000_FFFF}
) (
    input logic CLK,
    input logic RST,
    ahb_lite_interconnect_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERR1,
        ST_ERR2
    } def_state_t;

    logic [NUM_SLAVES-1:0] w_dec_sel;
    logic                  w_hit;
    logic [NUM_SLAVES:0]   r_dsel;      // MSB = default slave
    def_state_t            r_state;
    def_state_t            w_state_nxt;
    logic                  w_err_start;
    logic                  w_def_ready;
    logic                  w_def_resp;

    // Address decode: first (lowest-index) matching region wins
    always_comb begin
        w_dec_sel = '0;
        w_hit     = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!w_hit &&
                (bus.m_haddr >= SLAVE_BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                (bus.m_haddr <= SLAVE_LAST_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                w_dec_sel[i] = 1'b1;
                w_hit        = 1'b1;
            end
        end
    end

    // Data-phase select register, advances only when the bus is ready
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dsel <= {1'b1, {NUM_SLAVES{1'b0}}};
        end else if (bus.m_hready) begin
            r_dsel <= {~w_hit, w_dec_sel};
        end
    end

    // Default slave state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_err_start = bus.m_hready && !w_hit && bus.m_htrans[1];

    // Default slave outputs depend only on state, keeping m_hready loop-free
    assign w_def_ready = (r_state != ST_ERR1);
    assign w_def_resp  = (r_state != ST_IDLE);

    // Default slave next-state: two-cycle ERROR for active unmapped transfers
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_err_start) w_state_nxt = ST_ERR1;
            ST_ERR1: w_state_nxt = ST_ERR2;
            ST_ERR2: w_state_nxt = w_err_start ? ST_ERR1 : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Response and read-data mux driven by the data-phase select
    always_comb begin
        bus.m_hrdata = '0;
        bus.m_hready = w_def_ready;
        bus.m_hresp  = w_def_resp;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (r_dsel[i]) begin
                bus.m_hrdata = bus.s_hrdata[i*DATA_WIDTH +: DATA_WIDTH];
                bus.m_hready = bus.s_hreadyout[i];
                bus.m_hresp  = bus.s_hresp[i];
            end
        end
    end

    assign bus.s_hsel      = w_dec_sel;
    assign bus.s_haddr     = bus.m_haddr;
    assign bus.s_htrans    = bus.m_htrans;
    assign bus.s_hwrite    = bus.m_hwrite;
    assign bus.s_hsize     = bus.m_hsize;
    assign bus.s_hburst    = bus.m_hburst;
    assign bus.s_hprot     = bus.m_hprot;
    assign bus.s_hmastlock = bus.m_hmastlock;
    assign bus.s_hwdata    = bus.m_hwdata;
    assign bus.s_hready    = bus.m_hready;

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Testbench for ahb_lite_interconnect: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_ahb_lite_interconnect;

    localparam int unsigned NS = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    ahb_lite_interconnect_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    ahb_lite_interconnect_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) obus ();

    ahb_lite_interconnect #(
        .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .SLAVE_BASE_ADDR({32'h0001_0000, 32'h0000_0000}),
        .SLAVE_LAST_ADDR({32'h0001_00FF, 32'h0000_FFFF})
    ) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Overlapping regions: slave1 base falls inside slave0
    ahb_lite_interconnect #(
        .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .SLAVE_BASE_ADDR({32'h0000_8000, 32'h0000_0000}),
        .SLAVE_LAST_ADDR({32'h0001_00FF, 32'h0000_FFFF})
    ) u_ovl (
        .CLK (CLK),
        .RST (RST),
        .bus (obus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Region table for the main DUT
    logic [31:0] reg_base [NS] = '{32'h0000_0000, 32'h0001_0000};
    logic [31:0] reg_last [NS] = '{32'h0000_FFFF, 32'h0001_00FF};

    function automatic int ref_target(input logic [31:0] a);
        int t = -1;
        for (int k = NS - 1; k >= 0; k--)
            if (a >= reg_base[k] && a <= reg_last[k]) t = k;
        return t;
    endfunction

    // Reference model: which target owns the data phase, and how many
    // ERROR response cycles remain for an unmapped active transfer.
    int          mdl_tgt    = -1;
    int          mdl_err    = 0;
    logic        last_ready = 1'b1;

    // Held master request
    logic [31:0] h_addr;
    logic [1:0]  h_trans;
    logic        h_write;
    logic [31:0] h_wdata;

    // Observations from the most recent step
    logic [31:0] obs_rdata;
    logic        obs_ready;
    logic        obs_resp;
    logic [1:0]  obs_sel;
    logic [31:0] obs_haddr;

    task automatic apply_master();
        bus.m_haddr     = h_addr;
        bus.m_htrans    = h_trans;
        bus.m_hwrite    = h_write;
        bus.m_hwdata    = h_wdata;
        bus.m_hsize     = 3'd2;
        bus.m_hburst    = 3'd0;
        bus.m_hprot     = 4'h3;
        bus.m_hmastlock = 1'b0;
    endtask

    task automatic model_reset();
        mdl_tgt    = -1;
        mdl_err    = 0;
        last_ready = 1'b1;
    endtask

    // One bus cycle: drive at negedge, check, then advance the model at posedge
    task automatic step(input logic [31:0] a, input logic [1:0] tr, input logic wr,
                        input logic [1:0] rdy, input logic [1:0] rsp,
                        input logic [31:0] d0, input logic [31:0] d1);
        int          t;
        logic [1:0]  e_sel;
        logic        e_ready;
        logic        e_resp;
        logic [31:0] e_rdata;
        @(negedge CLK);
        if (last_ready) begin
            h_addr  = a;
            h_trans = tr;
            h_write = wr;
            h_wdata = $urandom;
        end
        apply_master();
        bus.s_hreadyout = rdy;
        bus.s_hresp     = rsp;
        bus.s_hrdata    = {d1, d0};
        #1;
        t     = ref_target(h_addr);
        e_sel = (t >= 0) ? 2'(1 << t) : 2'b00;
        if (mdl_tgt >= 0) begin
            e_ready = rdy[mdl_tgt];
            e_resp  = rsp[mdl_tgt];
            e_rdata = (mdl_tgt == 1) ? d1 : d0;
        end else begin
            e_ready = (mdl_err != 2);
            e_resp  = (mdl_err != 0);
            e_rdata = '0;
        end
        obs_rdata = bus.m_hrdata;
        obs_ready = bus.m_hready;
        obs_resp  = bus.m_hresp;
        obs_sel   = bus.s_hsel;
        obs_haddr = bus.s_haddr;
        check_val("hsel",    64'(bus.s_hsel),    64'(e_sel));
        check_val("hready",  64'(bus.m_hready),  64'(e_ready));
        check_val("hresp",   64'(bus.m_hresp),   64'(e_resp));
        check_val("hrdata",  64'(bus.m_hrdata),  64'(e_rdata));
        check_val("s_haddr", 64'(bus.s_haddr),   64'(h_addr));
        check_val("s_hwdata",64'(bus.s_hwdata),  64'(h_wdata));
        check_val("s_hready",64'(bus.s_hready),  64'(e_ready));
        @(posedge CLK);
        if (e_ready) begin
            mdl_tgt = t;
            mdl_err = (t < 0 && h_trans[1]) ? 2 : 0;
        end else if (mdl_err > 0) begin
            mdl_err--;
        end
        last_ready = e_ready;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0: return 32'($urandom_range(0, 32'h0000_FFFF));
            1: return 32'h0000_FFFF;
            2: return 32'h0001_0000;
            3: return 32'h0001_00FF;
            4: return 32'h0001_0100;
            5: return 32'h0002_0000 + 32'($urandom_range(0, 32'hFFFF));
            6: return 32'h0001_0000 + 32'($urandom_range(0, 32'hFF));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset with an active request present
        RST     = 1'b1;
        h_addr  = 32'h0000_0010;
        h_trans = T_NONSEQ;
        h_write = 1'b0;
        h_wdata = '0;
        apply_master();
        bus.s_hreadyout = 2'b11;
        bus.s_hresp     = 2'b00;
        bus.s_hrdata    = {32'h1111_1111, 32'h2222_2222};
        obus.m_haddr = '0; obus.m_htrans = T_IDLE; obus.m_hwrite = 1'b0;
        obus.m_hsize = 3'd2; obus.m_hburst = 3'd0; obus.m_hprot = 4'h3;
        obus.m_hmastlock = 1'b0; obus.m_hwdata = '0;
        obus.s_hreadyout = 2'b11; obus.s_hresp = 2'b00; obus.s_hrdata = '0;
        #2;
        check_val("rst_hready", 64'(bus.m_hready), 64'(1'b1));
        check_val("rst_hresp",  64'(bus.m_hresp),  64'(1'b0));
        check_val("rst_hrdata", 64'(bus.m_hrdata), 64'(32'h0));
        check_val("rst_hsel0",  64'(bus.s_hsel),   64'(2'b01));
        h_addr = 32'h0001_0000;
        apply_master();
        #1;
        check_val("rst_hsel1",  64'(bus.s_hsel),   64'(2'b10));
        // Unmapped IDLE while releasing keeps DUT equal to the reset model
        h_addr  = 32'h0002_0000;
        h_trans = T_IDLE;
        apply_master();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();

        // Zero-wait read from slave0
        step(32'h0000_0010, T_NONSEQ, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
        check_val("rd_addr_sel", 64'(obs_sel), 64'(2'b01));
        step(32'h0000_0000, T_IDLE, 1'b0, 2'b11, 2'b00, 32'hDEAD_BEEF, 32'h0);
        check_val("rd_data",  64'(obs_rdata), 64'(32'hDEAD_BEEF));
        check_val("rd_ready", 64'(obs_ready), 64'(1'b1));
        check_val("rd_resp",  64'(obs_resp),  64'(1'b0));

        // Write slave1 with 2 waits, then slave0 read held behind it
        step(32'h0001_0004, T_NONSEQ, 1'b1, 2'b11, 2'b00, 32'h0, 32'h0);
        step(32'h0000_0008, T_NONSEQ, 1'b0, 2'b01, 2'b00, 32'h0, 32'h0);
        check_val("wait1_ready", 64'(obs_ready), 64'(1'b0));
        step(32'h0000_0FF0, T_IDLE, 1'b0, 2'b01, 2'b00, 32'h0, 32'h0);
        check_val("wait2_ready", 64'(obs_ready), 64'(1'b0));
        check_val("wait2_addr",  64'(obs_haddr), 64'(32'h0000_0008));
        step(32'h0000_0FF0, T_IDLE, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
        check_val("wait_done",   64'(obs_ready), 64'(1'b1));
        step(32'h0000_0000, T_IDLE, 1'b0, 2'b11, 2'b00, 32'h1234_5678, 32'h0);
        check_val("b2b_data",    64'(obs_rdata), 64'(32'h1234_5678));

        // Unmapped NONSEQ -> two-cycle ERROR, then OKAY
        step(32'h0002_0000, T_NONSEQ, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
        step(32'h0000_0000, T_IDLE, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
        check_val("err1_ready", 64'(obs_ready), 64'(1'b0));
        check_val("err1_resp",  64'(obs_resp),  64'(1'b1));
        step(32'h0002_0000, T_IDLE, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
        check_val("err2_ready", 64'(obs_ready), 64'(1'b1));
        check_val("err2_resp",  64'(obs_resp),  64'(1'b1));
        step(32'h0002_0000, T_IDLE, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
        check_val("idle_unmapped_resp", 64'(obs_resp), 64'(1'b0));
        step(32'h0000_0000, T_IDLE, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
        check_val("idle_unmapped_ready", 64'(obs_ready), 64'(1'b1));

        // Region boundaries
        step(32'h0000_FFFF, T_NONSEQ, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
        check_val("bnd_last0", 64'(obs_sel), 64'(2'b01));
        step(32'h0001_0000, T_NONSEQ, 1'b0, 2'b11, 2'b00, 32'h0000_AAAA, 32'h0);
        check_val("bnd_base1", 64'(obs_sel), 64'(2'b10));
        check_val("bnd_data0", 64'(obs_rdata), 64'(32'h0000_AAAA));
        step(32'h0001_0100, T_NONSEQ, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0000_BBBB);
        check_val("bnd_past1", 64'(obs_sel), 64'(2'b00));
        check_val("bnd_data1", 64'(obs_rdata), 64'(32'h0000_BBBB));
        step(32'h0000_0000, T_IDLE, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
        check_val("bnd_err1", 64'({obs_ready, obs_resp}), 64'(2'b01));
        step(32'h0000_0000, T_IDLE, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
        check_val("bnd_err2", 64'({obs_ready, obs_resp}), 64'(2'b11));

        // Overlapping regions: lowest index wins
        obus.m_haddr = 32'h0000_9000; #1;
        check_val("ovl_9000",  64'(obus.s_hsel), 64'(2'b01));
        obus.m_haddr = 32'h0000_8000; #1;
        check_val("ovl_8000",  64'(obus.s_hsel), 64'(2'b01));
        obus.m_haddr = 32'h0001_0000; #1;
        check_val("ovl_10000", 64'(obus.s_hsel), 64'(2'b10));
        obus.m_haddr = 32'h0002_0000; #1;
        check_val("ovl_none",  64'(obus.s_hsel), 64'(2'b00));

        // Reset asserted while the default slave is in its first ERROR cycle
        step(32'h0002_0000, T_NONSEQ, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
        #2;
        check_val("pre_rst_ready", 64'(bus.m_hready), 64'(1'b0));
        RST = 1'b1;
        #1;
        check_val("mid_rst_ready", 64'(bus.m_hready), 64'(1'b1));
        check_val("mid_rst_resp",  64'(bus.m_hresp),  64'(1'b0));
        h_addr  = 32'h0002_0000;
        h_trans = T_IDLE;
        apply_master();
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        step(32'h0000_0010, T_NONSEQ, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0);
        check_val("post_rst_sel", 64'(obs_sel), 64'(2'b01));
        step(32'h0000_0000, T_IDLE, 1'b0, 2'b11, 2'b00, 32'h0000_CAFE, 32'h0);
        check_val("post_rst_data", 64'(obs_rdata), 64'(32'h0000_CAFE));

        // Randomized traffic against the reference model
        for (int n = 0; n < 500; n++) begin
            step(rand_addr(), 2'($urandom_range(0, 3)), 1'($urandom),
                 {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)},
                 {1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0)},
                 $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
